hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller. It drives the `stall` input of the ID/EX pipeline register and the hold/flush controls of the fetch and IF/ID stages. It detects three conditions: load-use hazards between the ID and EX stages, taken branches and jumps resolved in EX, and data-memory wait states. It also keeps saturating performance counters of lost cycles.

## Interface
- `LOAD_WBSEL`, default 2'b01: `ex_wbsel` encoding that selects data-memory writeback (a load).
- `CNT_W`, default 16: width of `stall_cnt`.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `id_rs1addr` in 5: rs1 address of the instruction in ID.
- `id_rs2addr` in 5: rs2 address of the instruction in ID.
- `id_rs1used` in 1: the ID instruction reads rs1.
- `id_rs2used` in 1: the ID instruction reads rs2.
- `ex_rdaddr` in 5: destination address of the instruction in EX.
- `ex_regwr` in 1: the EX instruction writes the register file.
- `ex_wbsel` in 2: writeback select of the EX instruction.
- `ex_brtaken` in 1: the branch or jump in EX is taken (redirect).
- `mem_req` in 1: the MEM stage has a data-memory access outstanding.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_hold` out 1: freeze the PC.
- `if_id_hold` out 1: freeze the IF/ID register.
- `stall` out 1: stall input of the ID/EX register (bubble into EX).
- `ex_mem_hold` out 1: freeze the EX/MEM and MEM/WB registers.
- `if_id_flush` out 1: squash the IF/ID contents at the next edge.
- `id_ex_flush` out 1: squash the ID/EX contents at the next edge.
- `stall_cnt` out CNT_W: saturating count of cycles with `pc_hold`=1.
- `flush_cnt` out 8: saturating count of redirect events.

## Operation
- The FSM has states RUN, LDUSE, FLUSH and MEMWAIT, encoded in 2 bits. Reset state is RUN.
- Combinational terms:
  - `mw` = `mem_req` & !`dmem_ready`.
  - `lu` = `ex_regwr` & (`ex_wbsel`==LOAD_WBSEL) & (`ex_rdaddr`!=0) & ((`id_rs1used` & `id_rs1addr`==`ex_rdaddr`) | (`id_rs2used` & `id_rs2addr`==`ex_rdaddr`)).
  - `lu` is masked (treated as 0) while the state is LDUSE or FLUSH.
- Priority is `mw` > `ex_brtaken` > `lu`.
- `mw`=1, in any state:
  - Outputs: `pc_hold`=`if_id_hold`=`ex_mem_hold`=1, `stall`=1, both flushes 0.
  - Next state MEMWAIT.
  - A pending `ex_brtaken` is not acted on. EX is frozen, so it persists and is serviced on the first cycle with `mw`=0.
- `mw`=0 and `ex_brtaken`=1:
  - Outputs: `if_id_flush`=`id_ex_flush`=1, all holds 0, `stall`=0.
  - Next state FLUSH.
  - `flush_cnt` increments.
- `mw`=0, no branch, and `lu`=1 (unmasked):
  - Outputs: `pc_hold`=`if_id_hold`=`stall`=1, `ex_mem_hold`=0.
  - Next state LDUSE.
- Otherwise all control outputs are 0 and the next state is RUN.
  - LDUSE and FLUSH each last exactly one cycle, then return to RUN unless `mw`, a branch or an unmasked `lu` applies.
  - MEMWAIT exits on the first cycle with `mw`=0, and that cycle's outputs follow the rules above.
- Counters:
  - `stall_cnt` increments by 1 on each edge where `pc_hold`=1 and saturates at all-ones.
  - `flush_cnt` saturates at 8'hFF.
  - Counters are never cleared except by reset.

## Timing
- Outputs are Mealy: combinational from the registered state and the current inputs. There is no added latency.
- State and counters update on the rising edge of `clk`.
- Reset (asynchronous, any cycle, including mid-MEMWAIT): state RUN, `stall_cnt`=0, `flush_cnt`=0.
  - While `rst_n`=0, all control outputs are forced to 0.
  - The first edge after release evaluates from RUN.
- A load-use hazard costs exactly 1 bubble cycle; a back-to-back dependent pair never costs 2.
- A taken branch costs 2 squashed slots in the same cycle, with no hold.
- A memory wait of N cycles holds the whole pipeline for N cycles and adds N to `stall_cnt`.
- Simultaneous `ex_brtaken` and `lu`: only the flush is produced, `stall`=0, and no LDUSE entry.
- A write to x0 never causes a stall.

## Test plan
- Load-use: reset, then a load to x5 in EX (`ex_regwr`=1, `ex_wbsel`=01, `ex_rdaddr`=5) with `id_rs2addr`=5 and `id_rs2used`=1.
  - Response: `stall`/`pc_hold`/`if_id_hold`=1 for exactly 1 cycle, then 0 with the same inputs (LDUSE mask), and `stall_cnt`=1.
- x0 and unused operands:
  - `ex_rdaddr`=0 with a matching `id_rs1addr`=0 → no stall.
  - A match on rs1 with `id_rs1used`=0 → no stall.
  - An ALU writer (`ex_wbsel`=00) with a match → no stall.
- Branch vs load-use: `ex_brtaken`=1 and `lu`=1 in the same cycle.
  - Response: `if_id_flush`=`id_ex_flush`=1, `stall`=0, `flush_cnt`=1, and FLUSH masks `lu` on the next cycle.
- Memory wait: `mem_req`=1, `dmem_ready`=0 for 3 cycles with `ex_brtaken`=1 held.
  - Response: all holds and `stall`=1 for 3 cycles with no flush, then a flush on cycle 4 when `dmem_ready`=1. `stall_cnt`=3, `flush_cnt`=1.
- Saturation: force 70000 wait cycles → `stall_cnt`=16'hFFFF. 300 branches → `flush_cnt`=8'hFF.
- Reset mid-MEMWAIT: assert `rst_n`=0 asynchronously during a wait.
  - Response: outputs and counters go to 0 immediately, and the FSM resumes in RUN after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller for load-use, redirect and dmem wait,
//            with saturating lost-cycle counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter logic [1:0] LOAD_WBSEL = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1addr,
    input  logic [4:0]       id_rs2addr,
    input  logic             id_rs1used,
    input  logic             id_rs2used,
    input  logic [4:0]       ex_rdaddr,
    input  logic             ex_regwr,
    input  logic [1:0]       ex_wbsel,
    input  logic             ex_brtaken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             stall,
    output logic             ex_mem_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [7:0]       flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_mw;
    logic             w_lu_raw;
    logic             w_lu;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [7:0]       r_flush_cnt;

    assign w_mw     = mem_req & ~dmem_ready;
    assign w_lu_raw = ex_regwr & (ex_wbsel == LOAD_WBSEL) & (ex_rdaddr != 5'd0) &
                      ((id_rs1used & (id_rs1addr == ex_rdaddr)) |
                       (id_rs2used & (id_rs2addr == ex_rdaddr)));
    // The instruction behind a bubble or a squash was already handled; don't re-stall it.
    assign w_lu     = w_lu_raw & (r_state != ST_LDUSE) & (r_state != ST_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        stall       = 1'b0;
        ex_mem_hold = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            w_state_nxt = ST_RUN;
        end else if (w_mw) begin
            // A pending redirect stays frozen in EX and is taken once memory is ready.
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            stall       = 1'b1;
            ex_mem_hold = 1'b1;
            w_state_nxt = ST_MEMWAIT;
        end else if (ex_brtaken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_state_nxt = ST_FLUSH;
        end else if (w_lu) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            stall       = 1'b1;
            w_state_nxt = ST_LDUSE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (if_id_flush && (r_flush_cnt != 8'hFF)) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
